// File: rtl/freq_period_meter.sv
//----------------------------------------------------------------------------
// freq_period_meter
//
// Measures the period and the high time of a slow, asynchronous input,
// counted in clk_in cycles. The input passes through a 2-flop synchronizer.
// A third flop provides rising-edge detection. Successive rising edges
// bracket one measurement.
//
// Optional build macro: DUTY_PCT_EN. When it is defined, a sequential
// restoring divider produces floor(high*100/period). When it is not defined,
// duty_pct and duty_valid are tied to 0.
//
// Ports:
//   clk_in      in   system clock; all logic runs on its rising edge
//   rst         in   asynchronous active-high reset
//   sig_in      in   signal under measurement (asynchronous)
//   period_out  out  [CNT_W] last measured period, in clk_in cycles
//   high_out    out  [CNT_W] last measured high time, in clk_in cycles
//   meas_valid  out  one-cycle pulse when period_out/high_out update
//   timeout     out  level: no rising edge for TIMEOUT_CYC cycles
//   duty_pct    out  [7] duty cycle in integer percent, floored
//   duty_valid  out  one-cycle pulse when duty_pct updates
//
// Strobe semantics: meas_valid and duty_valid are single-cycle pulses with no
// back-pressure. The matching data outputs are valid in the pulse cycle. They
// hold their value until the next pulse, or until a timeout zeroes them.
//----------------------------------------------------------------------------
`timescale 1ns/1ps
module freq_period_meter #(
  parameter int INPUT_HZ    = 100_000_000,
  parameter int CNT_W       = 24,
  parameter int TIMEOUT_CYC = INPUT_HZ / 100
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             timeout,
  output logic [6:0]       duty_pct,
  output logic             duty_valid
);

  localparam logic ST_IDLE    = 1'b0;
  localparam logic ST_MEASURE = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT_CYC);

  logic             state;
  logic             s1, s2, s3;
  logic             rise;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] hi_cnt;

  assign rise = s2 & ~s3;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      per_cnt    <= '0;
      hi_cnt     <= '0;
      period_out <= '0;
      high_out   <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      s1         <= sig_in;
      s2         <= s1;
      s3         <= s2;
      meas_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          // The first edge after reset or timeout only opens a window.
          if (rise) begin
            per_cnt <= CNT_ONE;
            hi_cnt  <= CNT_ONE;
            state   <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          // An edge that lands on the timeout cycle still counts as a
          // measurement, so the edge test comes first.
          if (rise) begin
            period_out <= per_cnt;
            high_out   <= hi_cnt;
            meas_valid <= 1'b1;
            timeout    <= 1'b0;
            per_cnt    <= CNT_ONE;
            hi_cnt     <= CNT_ONE;
          end else if (per_cnt == TO_VAL) begin
            timeout    <= 1'b1;
            period_out <= '0;
            high_out   <= '0;
            state      <= ST_IDLE;
          end else begin
            if (per_cnt != CNT_MAX) per_cnt <= per_cnt + 1'b1;
            if (s2 && (hi_cnt != CNT_MAX)) hi_cnt <= hi_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DUTY_PCT_EN
  localparam int DW = CNT_W + 7;

  logic          to_fire;
  logic [DW-1:0] div_rem;
  logic [DW-1:0] den_sh;
  logic [DW-1:0] rem_next;
  logic [6:0]    div_q;
  logic [6:0]    q_next;
  logic [2:0]    div_idx;
  logic          div_busy;
  logic          ge;

  // This matches the timeout branch of the FSM above.
  assign to_fire = (state == ST_MEASURE) && !rise && (per_cnt == TO_VAL);

  // There is one quotient bit per iteration, MSB first. period_out is stable
  // for the whole division. Either a new measurement aborts the division, or
  // a timeout does.
  assign den_sh   = DW'(period_out) << div_idx;
  assign ge       = (div_rem >= den_sh);
  assign rem_next = ge ? (div_rem - den_sh) : div_rem;
  assign q_next   = {div_q[5:0], ge};

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      div_rem    <= '0;
      div_q      <= '0;
      div_idx    <= '0;
      div_busy   <= 1'b0;
      duty_pct   <= '0;
      duty_valid <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      if (to_fire) begin
        div_busy <= 1'b0;
        duty_pct <= '0;
      end else if (meas_valid) begin
        div_rem  <= DW'(high_out) * DW'(100);
        div_q    <= '0;
        div_idx  <= 3'd6;
        div_busy <= 1'b1;
      end else if (div_busy) begin
        div_rem <= rem_next;
        div_q   <= q_next;
        if (div_idx == 3'd0) begin
          div_busy   <= 1'b0;
          duty_pct   <= (q_next > 7'd100) ? 7'd100 : q_next;
          duty_valid <= 1'b1;
        end else begin
          div_idx <= div_idx - 3'd1;
        end
      end
    end
  end
`else
  assign duty_pct   = 7'd0;
  assign duty_valid = 1'b0;
`endif

endmodule

// File: tb/tb_freq_period_meter.sv
//----------------------------------------------------------------------------
// Testbench for freq_period_meter.
// The stimulus is a series of segments. Each segment is a rising edge, then a
// high time, then a low time, all in ns. The reference model works on the
// rising-edge times:
//   - Two consecutive rises no more than TIMEOUT_CYC cycles apart give one
//     measurement. Its period is the gap and its high time is the first
//     segment's high time. Both are exact for clock-aligned input, and within
//     one cycle otherwise.
//   - A longer gap gives a timeout event TIMEOUT_CYC cycles after the rise.
//   - Each result is sampled 2..3 cycles after its reference instant,
//     counting 2 synchronizer cycles and 1 register cycle.
// A monitor pops expectations whenever the DUT presents a result.
//----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_freq_period_meter;

  localparam int CNT_W  = 24;
  localparam int TO_CYC = 1000;
  localparam int CLK_NS = 10;

  // ---------------- clock / reset ----------------
  logic             clk_in = 1'b0;
  logic             rst;
  logic             sig_in;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             meas_valid;
  logic             timeout;
  logic [6:0]       duty_pct;
  logic             duty_valid;

  always #(CLK_NS/2) clk_in = ~clk_in;

  freq_period_meter #(
    .INPUT_HZ   (100_000_000),
    .CNT_W      (CNT_W),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .sig_in    (sig_in),
    .period_out(period_out),
    .high_out  (high_out),
    .meas_valid(meas_valid),
    .timeout   (timeout),
    .duty_pct  (duty_pct),
    .duty_valid(duty_valid)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    bit     is_to;
    longint per_ns;
    longint high_ns;
    longint base_ns;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void check(string name, bit ok, longint act, longint req);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  bit     have_prev = 1'b0;
  longint prev_t    = 0;
  longint prev_h    = 0;

  function automatic void model_rise(longint t, longint h, longint l);
    exp_t e;
    if (have_prev) begin
      e.is_to   = 1'b0;
      e.per_ns  = t - prev_t;
      e.high_ns = prev_h;
      e.base_ns = t;
      exp_q.push_back(e);
    end
    if (h + l > longint'(TO_CYC) * CLK_NS) begin
      e.is_to   = 1'b1;
      e.per_ns  = 0;
      e.high_ns = 0;
      e.base_ns = t + longint'(TO_CYC) * CLK_NS;
      exp_q.push_back(e);
      have_prev = 1'b0;
    end else begin
      have_prev = 1'b1;
      prev_t    = t;
      prev_h    = h;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_seg(input longint h_ns, input longint l_ns);
    longint t, h, l;
    t = $time;
    h = h_ns;
    l = l_ns;
    // Keep every edge off a rising clock edge (posedges sit at 5 mod 10).
    if ((t + h) % CLK_NS == 5) h++;
    if ((t + h + l) % CLK_NS == 5) l++;
    model_rise(t, h, l);
    sig_in = 1'b1;
    #(h);
    sig_in = 1'b0;
    #(l);
  endtask

  task automatic drive_cyc(input int h_cyc, input int l_cyc);
    drive_seg(longint'(h_cyc) * CLK_NS, longint'(l_cyc) * CLK_NS);
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    longint s, d;
    longint pend_t;
    int     pend_val;
    exp_t   e;
    bit     prev_mv, prev_to, pend;
    prev_mv  = 1'b0;
    prev_to  = 1'b0;
    pend     = 1'b0;
    pend_t   = 0;
    pend_val = -1;
    forever begin
      @(negedge clk_in);
      s = $time;
      if (rst) begin
        check("reset_outputs",
              (period_out == 0) && (high_out == 0) && !meas_valid && !timeout &&
              (duty_pct == 0) && !duty_valid,
              longint'(period_out) + longint'(high_out) + longint'(meas_valid) +
              longint'(timeout) + longint'(duty_pct) + longint'(duty_valid), 0);
        prev_mv = 1'b0;
        prev_to = 1'b0;
        pend    = 1'b0;
      end else begin
`ifdef DUTY_PCT_EN
        if (duty_valid) begin
          check("duty_valid_timing", pend && (s == pend_t + 8 * CLK_NS), s, pend_t + 8 * CLK_NS);
          if (pend && pend_val >= 0) check("duty_pct", duty_pct == pend_val, duty_pct, pend_val);
          pend = 1'b0;
        end else if (pend && (s == pend_t + 8 * CLK_NS)) begin
          check("duty_valid_missing", 1'b0, 0, 1);
          pend = 1'b0;
        end
`endif
        if (meas_valid) begin
          check("meas_spacing", !prev_mv, 1, 0);
          if (exp_q.size() == 0) begin
            check("meas_unexpected", 1'b0, period_out, 0);
          end else begin
            e = exp_q.pop_front();
            if (e.is_to) begin
              check("meas_instead_of_timeout", 1'b0, period_out, 0);
            end else begin
              d = longint'(period_out) * CLK_NS - e.per_ns;
              check("period_out", (d > -CLK_NS) && (d < CLK_NS), period_out, e.per_ns / CLK_NS);
              d = longint'(high_out) * CLK_NS - e.high_ns;
              check("high_out", (d > -CLK_NS) && (d < CLK_NS), high_out, e.high_ns / CLK_NS);
              check("timeout_clear_on_meas", !timeout, timeout, 0);
              check("meas_time", (s > e.base_ns + 25) && (s <= e.base_ns + 35), s, e.base_ns + 30);
`ifdef DUTY_PCT_EN
              pend   = 1'b1;
              pend_t = s;
              if ((e.per_ns % CLK_NS == 0) && (e.high_ns % CLK_NS == 0)) begin
                pend_val = int'((e.high_ns / CLK_NS) * 100 / (e.per_ns / CLK_NS));
                if (pend_val > 100) pend_val = 100;
              end else begin
                pend_val = -1;
              end
`else
              check("duty_off", (duty_pct == 0) && !duty_valid, duty_pct, 0);
`endif
            end
          end
        end
        if (timeout && !prev_to) begin
          pend = 1'b0;
          if (exp_q.size() == 0) begin
            check("timeout_unexpected", 1'b0, 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("timeout_kind", e.is_to, 1, longint'(e.is_to));
            check("timeout_zeroes_outputs",
                  (period_out == 0) && (high_out == 0) && (duty_pct == 0),
                  longint'(period_out) + longint'(high_out) + longint'(duty_pct), 0);
            check("timeout_time", (s > e.base_ns + 25) && (s <= e.base_ns + 35), s, e.base_ns + 30);
          end
        end
        if (!timeout && prev_to && !meas_valid) check("timeout_held", 1'b0, 0, 1);
        prev_mv = meas_valid;
        prev_to = timeout;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int p, h;
    rst    = 1'b1;
    sig_in = 1'b0;
    // Reset held with the input toggling: all outputs must stay 0.
    repeat (5) begin
      @(posedge clk_in);
      #2 sig_in = ~sig_in;
    end
    sig_in = 1'b0;
    @(posedge clk_in);
    #2 rst = 1'b0;
    have_prev = 1'b0;
    repeat (5) @(posedge clk_in);
    #2;

    // 100-cycle period, 25 high; the first rise yields nothing.
    repeat (4) drive_cyc(25, 75);
    // 7/3, then period 6 (duty division is aborted each time).
    repeat (4) drive_cyc(3, 4);
    repeat (5) drive_cyc(3, 3);
    repeat (2) drive_cyc(25, 75);

    // Timeout boundary: a gap of exactly TO_CYC is measured, TO_CYC+1 times out.
    drive_cyc(10, TO_CYC - 10);
    drive_cyc(10, TO_CYC - 9);
    // 200-cycle wave, stopped low, then restarted.
    repeat (3) drive_cyc(100, 100);
    drive_cyc(100, TO_CYC + 200);
    repeat (2) drive_cyc(100, 100);
    repeat (3) drive_cyc(25, 75);

    // Random clock-aligned waves.
    repeat (25) begin
      p = $urandom_range(4, 160);
      h = $urandom_range(2, p - 2);
      drive_cyc(h, p - h);
    end

    // Reset pulsed 40 cycles into a 100-cycle period.
    drive_cyc(25, 15);
    rst = 1'b1;
    repeat (2) @(posedge clk_in);
    #2 rst = 1'b0;
    have_prev = 1'b0;
    #(40 * CLK_NS);
    repeat (3) drive_cyc(25, 75);

    // Asynchronous phase: near-50% wave at ~500 cycles, then short random ones.
    #1;
    repeat (8) drive_seg(longint'($urandom_range(2470, 2530)), longint'($urandom_range(2470, 2530)));
    repeat (8) drive_seg(longint'($urandom_range(30, 900)), longint'($urandom_range(30, 900)));

    // Final stop low, which must time out.
    drive_seg(500, longint'(TO_CYC + 100) * CLK_NS);
    #(50 * CLK_NS);
    check("queue_drained", exp_q.size() == 0, exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
